// File: rtl/threaded_register_file.sv
// Multi-thread register file: NUM_THREADS banks, two registered read ports, one write port,
// pending-load scoreboard and a multi-cycle clear sequencer. Define RF_BYPASS_EN for write-to-read forwarding.
module threaded_register_file #(
    parameter int CORE_ID     = 0,
    parameter int DATA_WIDTH  = 8,
    parameter int NUM_THREADS = 4,
    parameter int NUM_REGS    = 16,
    parameter int BASE_STRIDE = 2
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           rd_en,
    input  logic [$clog2(NUM_THREADS)-1:0] rd_thread,
    input  logic [$clog2(NUM_REGS)-1:0]    rd_addr1,
    input  logic [$clog2(NUM_REGS)-1:0]    rd_addr2,
    output logic [DATA_WIDTH-1:0]          rd_data1,
    output logic [DATA_WIDTH-1:0]          rd_data2,
    output logic                           rd_valid,
    output logic                           rd_hazard,
    input  logic                           wr_en,
    input  logic [$clog2(NUM_THREADS)-1:0] wr_thread,
    input  logic [$clog2(NUM_REGS)-1:0]    wr_addr,
    input  logic [DATA_WIDTH-1:0]          wr_data,
    input  logic                           pend_set,
    input  logic [$clog2(NUM_THREADS)-1:0] pend_thread,
    input  logic [$clog2(NUM_REGS)-1:0]    pend_addr,
    input  logic                           clear_start,
    output logic                           clear_busy,
    output logic [DATA_WIDTH-1:0]          debug_reg0
);

    localparam int TW = $clog2(NUM_THREADS);
    localparam int AW = $clog2(NUM_REGS);

    localparam logic [AW-1:0] RB_A   = AW'(NUM_REGS - 2);
    localparam logic [AW-1:0] RT_A   = AW'(NUM_REGS - 1);
    localparam logic [AW-1:0] LAST_A = AW'(NUM_REGS - 1);

    localparam logic [DATA_WIDTH-1:0] BASE_VAL = DATA_WIDTH'(CORE_ID * BASE_STRIDE);
    localparam logic [DATA_WIDTH-1:0] TID_BASE = DATA_WIDTH'(CORE_ID * NUM_THREADS);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_e;

    state_e                  state_q;
    logic [AW-1:0]           clr_idx_q;
    logic                    clear_busy_q;

    logic [DATA_WIDTH-1:0]   regs_q [NUM_THREADS][NUM_REGS];
    logic [NUM_REGS-1:0]     pend_q [NUM_THREADS];
    logic [NUM_REGS-1:0]     pend_d [NUM_THREADS];

    logic [DATA_WIDTH-1:0]   rd_data1_q;
    logic [DATA_WIDTH-1:0]   rd_data2_q;
    logic                    rd_valid_q;
    logic                    rd_hazard_q;

    logic                    wr_fire;
    logic                    pend_fire;
    logic                    clr_last;

    logic [AW-1:0]           op_addr [2];
    logic [DATA_WIDTH-1:0]   op_val  [2];
    logic [1:0]              op_hz;

    function automatic logic [DATA_WIDTH-1:0] launch_val(input logic [AW-1:0] a);
        return (a == RB_A) ? BASE_VAL : '0;
    endfunction

    function automatic logic [DATA_WIDTH-1:0] thread_id(input logic [TW-1:0] t);
        return TID_BASE + DATA_WIDTH'(t);
    endfunction

    // Writes and load marks only land while idle; RT is hard-wired and never stored into.
    assign wr_fire   = (state_q == ST_IDLE) && wr_en    && (wr_addr   != RT_A);
    assign pend_fire = (state_q == ST_IDLE) && pend_set && (pend_addr != RT_A);
    assign clr_last  = (state_q == ST_CLEAR) && (clr_idx_q == LAST_A);

    assign op_addr[0] = rd_addr1;
    assign op_addr[1] = rd_addr2;

    always_comb begin
        for (int p = 0; p < 2; p++) begin
            op_val[p] = regs_q[rd_thread][op_addr[p]];
            op_hz[p]  = pend_q[rd_thread][op_addr[p]];
            if (op_addr[p] == RT_A) begin
                op_val[p] = thread_id(rd_thread);
                op_hz[p]  = 1'b0;
            end
`ifdef RF_BYPASS_EN
            else if (wr_fire && (wr_thread == rd_thread) && (wr_addr == op_addr[p])) begin
                op_val[p] = wr_data;
                op_hz[p]  = 1'b0;
            end
`endif
        end
    end

    // Clear sequencer: one register index per cycle across all banks.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            clr_idx_q    <= '0;
            clear_busy_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (clear_start) begin
                        state_q      <= ST_CLEAR;
                        clr_idx_q    <= '0;
                        clear_busy_q <= 1'b1;
                    end
                end
                ST_CLEAR: begin
                    clr_idx_q <= clr_idx_q + AW'(1);
                    if (clr_idx_q == LAST_A) begin
                        state_q      <= ST_IDLE;
                        clear_busy_q <= 1'b0;
                    end
                end
                default: begin
                    state_q      <= ST_IDLE;
                    clear_busy_q <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int t = 0; t < NUM_THREADS; t++) begin
                for (int r = 0; r < NUM_REGS; r++) begin
                    regs_q[t][r] <= launch_val(AW'(r));
                end
            end
        end else if (state_q == ST_CLEAR) begin
            for (int t = 0; t < NUM_THREADS; t++) begin
                regs_q[t][clr_idx_q] <= launch_val(clr_idx_q);
            end
        end else if (wr_fire) begin
            regs_q[wr_thread][wr_addr] <= wr_data;
        end
    end

    // A load issued in the same cycle as a write to the same register wins: set after clear.
    always_comb begin
        for (int t = 0; t < NUM_THREADS; t++) begin
            pend_d[t] = pend_q[t];
        end
        if (clr_last) begin
            for (int t = 0; t < NUM_THREADS; t++) begin
                pend_d[t] = '0;
            end
        end else begin
            if (wr_fire) begin
                pend_d[wr_thread][wr_addr] = 1'b0;
            end
            if (pend_fire) begin
                pend_d[pend_thread][pend_addr] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int t = 0; t < NUM_THREADS; t++) begin
                pend_q[t] <= '0;
            end
        end else begin
            for (int t = 0; t < NUM_THREADS; t++) begin
                pend_q[t] <= pend_d[t];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_data1_q  <= '0;
            rd_data2_q  <= '0;
            rd_valid_q  <= 1'b0;
            rd_hazard_q <= 1'b0;
        end else begin
            rd_valid_q <= rd_en;
            if (rd_en) begin
                rd_data1_q  <= op_val[0];
                rd_data2_q  <= op_val[1];
                rd_hazard_q <= |op_hz;
            end
        end
    end

    assign rd_data1   = rd_data1_q;
    assign rd_data2   = rd_data2_q;
    assign rd_valid   = rd_valid_q;
    assign rd_hazard  = rd_hazard_q;
    assign clear_busy = clear_busy_q;
    assign debug_reg0 = regs_q[0][0];

endmodule

// File: tb/tb_threaded_register_file.sv
// Self-checking bench for threaded_register_file (CORE_ID=1): directed steps then random traffic
// against an array-based reference model.
module tb_threaded_register_file;

  localparam int DW  = 8;
  localparam int NT  = 4;
  localparam int NR  = 16;
  localparam int CID = 1;
  localparam int BS  = 2;
  localparam int TW  = 2;
  localparam int AW  = 4;
  localparam int RB  = NR - 2;
  localparam int RT  = NR - 1;
`ifdef RF_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic          clk;
  logic          reset;
  logic          rd_en;
  logic [TW-1:0] rd_thread;
  logic [AW-1:0] rd_addr1;
  logic [AW-1:0] rd_addr2;
  logic [DW-1:0] rd_data1;
  logic [DW-1:0] rd_data2;
  logic          rd_valid;
  logic          rd_hazard;
  logic          wr_en;
  logic [TW-1:0] wr_thread;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          pend_set;
  logic [TW-1:0] pend_thread;
  logic [AW-1:0] pend_addr;
  logic          clear_start;
  logic          clear_busy;
  logic [DW-1:0] debug_reg0;

  threaded_register_file #(
    .CORE_ID(CID), .DATA_WIDTH(DW), .NUM_THREADS(NT), .NUM_REGS(NR), .BASE_STRIDE(BS)
  ) dut (
    .clk(clk), .reset(reset),
    .rd_en(rd_en), .rd_thread(rd_thread), .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
    .rd_data1(rd_data1), .rd_data2(rd_data2), .rd_valid(rd_valid), .rd_hazard(rd_hazard),
    .wr_en(wr_en), .wr_thread(wr_thread), .wr_addr(wr_addr), .wr_data(wr_data),
    .pend_set(pend_set), .pend_thread(pend_thread), .pend_addr(pend_addr),
    .clear_start(clear_start), .clear_busy(clear_busy), .debug_reg0(debug_reg0)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // reference model
  logic [DW-1:0]     mem  [NT][NR];
  bit                pend [NT][NR];
  int                clear_left;
  logic [DW-1:0]     exp_d1, exp_d2;
  logic              exp_hz, exp_valid;
  logic [2*DW:0]     exp_q[$];
  int                n_checks;
  int                n_errors;

  function automatic logic [DW-1:0] launch(input int a);
    return (a == RB) ? DW'(CID * BS) : '0;
  endfunction

  task automatic model_reset();
    for (int t = 0; t < NT; t++)
      for (int r = 0; r < NR; r++) begin
        mem[t][r]  = launch(r);
        pend[t][r] = 1'b0;
      end
    clear_left = 0;
    exp_d1 = '0; exp_d2 = '0; exp_hz = 1'b0; exp_valid = 1'b0;
    exp_q.delete();
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic operand(input int t, input int a, input bit wr_ok,
                         output logic [DW-1:0] v, output logic hz);
    if (a == RT) begin
      v = DW'(CID * NT + t); hz = 1'b0;
    end else if (BYP && wr_ok && int'(wr_thread) == t && int'(wr_addr) == a) begin
      v = wr_data; hz = 1'b0;
    end else begin
      v = mem[t][a]; hz = pend[t][a];
    end
  endtask

  task automatic check_all();
    check("rd_valid",   32'(rd_valid),   32'(exp_valid));
    check("clear_busy", 32'(clear_busy), 32'(clear_left > 0));
    check("debug_reg0", 32'(debug_reg0), 32'(mem[0][0]));
    check("rd_data1",   32'(rd_data1),   32'(exp_d1));
    check("rd_data2",   32'(rd_data2),   32'(exp_d2));
    check("rd_hazard",  32'(rd_hazard),  32'(exp_hz));
  endtask

  // one clock: predict, advance model at the edge, check #1 later
  task automatic step();
    bit idle, wr_ok, pd_ok, rd_req, cs;
    int wt, wa, pt, pa;
    logic [DW-1:0] wd, v1, v2;
    logic h1, h2;
    idle  = (clear_left == 0);
    wr_ok = idle && wr_en && (int'(wr_addr) != RT);
    pd_ok = idle && pend_set && (int'(pend_addr) != RT);
    wt = int'(wr_thread); wa = int'(wr_addr); wd = wr_data;
    pt = int'(pend_thread); pa = int'(pend_addr);
    rd_req = rd_en; cs = clear_start;
    if (rd_req) begin
      operand(int'(rd_thread), int'(rd_addr1), wr_ok, v1, h1);
      operand(int'(rd_thread), int'(rd_addr2), wr_ok, v2, h2);
      exp_q.push_back({h1 | h2, v1, v2});
    end
    @(posedge clk);
    if (!idle) begin
      for (int t = 0; t < NT; t++) mem[t][NR - clear_left] = launch(NR - clear_left);
      clear_left--;
      if (clear_left == 0)
        for (int t = 0; t < NT; t++)
          for (int r = 0; r < NR; r++) pend[t][r] = 1'b0;
    end else begin
      if (cs) clear_left = NR;
      if (wr_ok) begin mem[wt][wa] = wd; pend[wt][wa] = 1'b0; end
      if (pd_ok) pend[pt][pa] = 1'b1;
    end
    exp_valid = rd_req;
    if (rd_req && exp_q.size() > 0) {exp_hz, exp_d1, exp_d2} = exp_q.pop_front();
    #1;
    check_all();
  endtask

  // driver tasks
  task automatic idle_in();
    rd_en = 0; rd_thread = '0; rd_addr1 = '0; rd_addr2 = '0;
    wr_en = 0; wr_thread = '0; wr_addr = '0; wr_data = '0;
    pend_set = 0; pend_thread = '0; pend_addr = '0; clear_start = 0;
  endtask

  task automatic set_rd(input int t, input int a1, input int a2);
    rd_en = 1; rd_thread = TW'(t); rd_addr1 = AW'(a1); rd_addr2 = AW'(a2);
  endtask

  task automatic set_wr(input int t, input int a, input int d);
    wr_en = 1; wr_thread = TW'(t); wr_addr = AW'(a); wr_data = DW'(d);
  endtask

  task automatic set_pend(input int t, input int a);
    pend_set = 1; pend_thread = TW'(t); pend_addr = AW'(a);
  endtask

  task automatic do_step();
    step();
    idle_in();
  endtask

  task automatic read_all();
    for (int t = 0; t < NT; t++)
      for (int r = 0; r < NR; r += 2) begin
        set_rd(t, r, r + 1);
        do_step();
      end
  endtask

  initial begin
    int busy_cnt;
    n_checks = 0;
    n_errors = 0;
    idle_in();
    reset = 1'b0;
    model_reset();
    #3;
    check_all();
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;

    // 1: launch values of base register and thread id
    set_rd(2, RB, RT); do_step();
    check("t1_base", 32'(rd_data1), 32'd2);
    check("t1_tid",  32'(rd_data2), 32'd6);
    do_step();

    // 2: plain write/read, RT write ignored
    set_wr(1, 3, 'hA5); do_step();
    set_rd(1, 3, 3); do_step();
    check("t2_wr", 32'(rd_data1), 32'hA5);
    set_rd(0, 3, 3); do_step();
    check("t2_other_bank", 32'(rd_data1), 32'h00);
    set_wr(1, RT, 'h11); do_step();
    set_rd(1, RT, 3); do_step();
    check("t2_rt_ro", 32'(rd_data1), 32'd5);

    // 3: same-cycle write and read
    set_wr(3, 5, 'h3C); set_rd(3, 5, 0); do_step();
    check("t3_bypass", 32'(rd_data1), BYP ? 32'h3C : 32'h00);

    // 4: scoreboard
    set_pend(0, 4); do_step();
    set_rd(0, 4, 0); do_step();
    check("t4_hz", 32'(rd_hazard), 32'd1);
    set_wr(0, 4, 'h7E); do_step();
    set_rd(0, 4, 0); do_step();
    check("t4_clr_hz", 32'(rd_hazard), 32'd0);
    check("t4_data", 32'(rd_data1), 32'h7E);
    set_pend(0, 4); set_wr(0, 4, 'h12); do_step();
    set_rd(0, 0, 4); do_step();
    check("t4_load_wins", 32'(rd_hazard), 32'd1);
    set_pend(1, RT); set_rd(1, RT, RT); do_step();
    set_rd(1, RT, RT); do_step();
    check("t4_rt_nohz", 32'(rd_hazard), 32'd0);

    // 5: fill, mark, clear; writes during the sweep are dropped
    for (int t = 0; t < NT; t++)
      for (int r = 0; r < NR - 2; r++) begin
        set_wr(t, r, 'hFF); do_step();
      end
    set_pend(2, 1); do_step();
    clear_start = 1; do_step();
    busy_cnt = 0;
    for (int i = 0; i < 40 && clear_busy; i++) begin
      busy_cnt++;
      set_wr($urandom_range(NT - 1), $urandom_range(NR - 2), $urandom_range(255));
      set_pend($urandom_range(NT - 1), $urandom_range(NR - 1));
      clear_start = 1;
      set_rd($urandom_range(NT - 1), $urandom_range(NR - 1), $urandom_range(NR - 1));
      do_step();
    end
    check("t5_busy_len", 32'(busy_cnt), 32'd16);
    read_all();
    set_rd(2, 1, RB); do_step();
    check("t5_r1", 32'(rd_data1), 32'd0);
    check("t5_base", 32'(rd_data2), 32'd2);
    check("t5_hz", 32'(rd_hazard), 32'd0);

    // 6: reset in the middle of a clear
    set_wr(0, 0, 'h5A); do_step();
    set_rd(0, 0, 1); do_step();
    clear_start = 1; do_step();
    for (int i = 0; i < 4; i++) do_step();
    #2;
    reset = 1'b0;
    #1;
    model_reset();
    check_all();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    check_all();
    clear_start = 1; do_step();
    busy_cnt = 0;
    for (int i = 0; i < 40 && clear_busy; i++) begin
      busy_cnt++;
      do_step();
    end
    check("t6_busy_len", 32'(busy_cnt), 32'd16);

    // random traffic
    for (int i = 0; i < 600; i++) begin
      int t, a;
      t = $urandom_range(NT - 1);
      a = $urandom_range(3) == 0 ? RT : $urandom_range(7);
      if ($urandom_range(1)) set_rd(t, a, $urandom_range(7));
      if ($urandom_range(1))
        set_wr($urandom_range(1) ? t : $urandom_range(NT - 1),
               $urandom_range(1) ? a : $urandom_range(NR - 1), $urandom_range(255));
      if ($urandom_range(3) == 0)
        set_pend($urandom_range(1) ? t : $urandom_range(NT - 1),
                 $urandom_range(1) ? a : $urandom_range(7));
      if ($urandom_range(79) == 0) clear_start = 1;
      do_step();
    end
    for (int i = 0; i < 20; i++) do_step();
    read_all();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/threaded_register_file.md
Name: threaded_register_file

Overview:
Per-core register file generalised to NUM_THREADS independent banks of NUM_REGS registers each. It provides two registered read ports with write-to-read bypass and one write port. A per-register pending-load scoreboard raises a hazard flag, and a multi-cycle clear sequencer restores every bank to its launch values. It sits between decode/issue and the ALU/LSU of each core.

Parameters:
CORE_ID, 0, core index; used for the base-address register and the global thread id.
DATA_WIDTH, 8, register width in bits.
NUM_THREADS, 4, number of banks; must be a power of 2 and at least 2.
NUM_REGS, 16, registers per bank; must be a power of 2 and at least 4.
BASE_STRIDE, 2, base-address step per core.
Derived (localparam): TW = $clog2(NUM_THREADS), AW = $clog2(NUM_REGS).
Special registers:
- RB = NUM_REGS-2 is the base register; launch value CORE_ID*BASE_STRIDE, truncated to DATA_WIDTH.
- RT = NUM_REGS-1 is the read-only thread id.

Ports:
clk  in  1  clock; all state updates on rising edge.
reset  in  1  asynchronous, active-low reset (asserted when 0).
rd_en  in  1  read request.
rd_thread  in  TW  bank to read.
rd_addr1  in  AW  register index, read port 1.
rd_addr2  in  AW  register index, read port 2.
rd_data1  out  DATA_WIDTH  registered read data, port 1.
rd_data2  out  DATA_WIDTH  registered read data, port 2.
rd_valid  out  1  high the cycle after an accepted rd_en.
rd_hazard  out  1  registered with rd_data; either operand was pending.
wr_en  in  1  write request.
wr_thread  in  TW  bank to write.
wr_addr  in  AW  register to write.
wr_data  in  DATA_WIDTH  write data.
pend_set  in  1  mark a register pending (load issued).
pend_thread  in  TW  bank for pend_set.
pend_addr  in  AW  register for pend_set.
clear_start  in  1  one-cycle pulse; start the clear sequence.
clear_busy  out  1  high while the clear sequencer runs.
debug_reg0  out  DATA_WIDTH  combinational view of bank 0, register 0.

Behaviour:
- Reset asserted (reset=0), asynchronously:
  - All registers become 0, except RB in every bank = base value.
  - Scoreboard all 0; FSM in IDLE.
  - rd_data1/2 = 0; rd_valid = 0; rd_hazard = 0; clear_busy = 0.
- Read-only register RT:
  - Reading RT returns CORE_ID*NUM_THREADS + rd_thread, truncated to DATA_WIDTH.
  - Writes and pend_set to RT are ignored.
  - RT never reports a hazard.
- Read timing: latency 1. When rd_en is sampled high, rd_data1/2, rd_hazard and rd_valid update at the next edge. rd_data holds its value when rd_en=0; rd_valid drops to 0.
- Write: when wr_en=1 and the FSM is in IDLE, the register is written at the edge. The same edge clears its scoreboard bit.
- Bypass: a same-cycle wr_en to the same thread/addr as a read operand is forwarded. rd_data returns wr_data, and that operand contributes no hazard.
- Scoreboard:
  - pend_set sets the bit at the edge.
  - pend_set and wr_en on the same thread/addr in the same cycle: the bit ends set (the new load wins); the write data is still stored.
  - rd_hazard = OR of the operands' bits as seen at the read cycle, after bypass.
- Clear FSM, states IDLE and CLEAR:
  - IDLE -> CLEAR on clear_start; an index counter is loaded with 0 and clear_busy goes high the next cycle.
  - In CLEAR, register[index] in all banks is restored to its launch value each cycle; index increments.
  - After index NUM_REGS-1 (NUM_REGS cycles total), the whole scoreboard clears and the FSM returns to IDLE.
  - In CLEAR: wr_en and pend_set are dropped; clear_start is ignored; reads are served and return current contents.
  - Reset mid-clear aborts to IDLE with the reset values above.
- Writes to out-of-range thread/addr cannot occur, because the widths exactly cover the parameters.

Optional Feature:
RF_BYPASS_EN defined: forwarding as above.
Not defined: a same-cycle read of the register being written returns the old contents. Hazard uses the pre-write scoreboard bit, so a pending operand reports rd_hazard=1. The write still lands at the edge.

Test Plan:
1. Reset release, CORE_ID=1, defaults: read T2 R14/R15 -> rd_data1=2, rd_data2=6, rd_valid=1 one cycle later, rd_hazard=0; debug_reg0=0.
2. Write T1 R3=0xA5, then read T1 R3 and T0 R3 next cycle -> 0xA5 and 0x00; a write of 0x11 to T1 R15 is ignored and a read still returns the thread id.
3. Same cycle: wr T3 R5=0x3C plus rd T3 R5 -> 0x3C with RF_BYPASS_EN; old value 0x00 without it.
4. pend_set T0 R4; read T0 R4 -> rd_hazard=1. Then wr T0 R4=0x7E -> next read has rd_hazard=0 and data 0x7E. Same-cycle pend_set+wr on T0 R4 -> a later read has hazard=1.
5. Fill T0–T3 R0–R13 with 0xFF, pend_set T2 R1, then clear_start -> clear_busy high for exactly 16 cycles. Writes issued during that window are lost. Afterwards all regs = 0, R14 = base, no hazards.
6. Drop reset to 0 at cycle 5 of a clear -> immediately clear_busy=0 and all outputs at reset values; after release a new clear_start runs the full 16 cycles.
